// File: rtl/adc_window_peak.sv
// Per-window max/min/peak-to-peak tracker for a 12-bit ADC sample stream.
// Optional windowed mean output when ADC_WIN_MEAN_EN is defined.
module adc_window_peak #(
    parameter int LOG2_WIN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [11:0] data_i,
    input  logic        valid_i,
    output logic [11:0] max_o,
    output logic [11:0] min_o,
    output logic [11:0] amp_o,
`ifdef ADC_WIN_MEAN_EN
    output logic [11:0] mean_o,
`endif
    output logic        valid_o,
    output logic [15:0] win_cnt_o
);

    localparam logic [LOG2_WIN-1:0] LAST = '1;

    logic [LOG2_WIN-1:0] r_cnt;
    logic [11:0]         r_run_max;
    logic [11:0]         r_run_min;
    logic [11:0]         r_max;
    logic [11:0]         r_min;
    logic [11:0]         r_amp;
    logic                r_valid;
    logic [15:0]         r_win_cnt;

    logic        w_acc;
    logic        w_last;
    logic [11:0] w_max;
    logic [11:0] w_min;

    assign w_acc  = valid_i & en_i;
    assign w_last = (r_cnt == LAST);
    assign w_max  = (data_i > r_run_max) ? data_i : r_run_max;
    assign w_min  = (data_i < r_run_min) ? data_i : r_run_min;

`ifdef ADC_WIN_MEAN_EN
    localparam int ACC_W = 12 + LOG2_WIN;

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_shift;
    logic [11:0]      r_mean;

    // Accumulator is wide enough for a full window of 0xFFF samples.
    assign w_sum   = r_acc + ACC_W'(data_i);
    assign w_shift = w_sum >> LOG2_WIN;
    assign mean_o  = r_mean;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_mean <= '0;
        end else if (!en_i) begin
            r_acc  <= '0;
        end else if (w_acc) begin
            if (w_last) begin
                r_acc  <= '0;
                r_mean <= 12'(w_shift);
            end else begin
                r_acc  <= w_sum;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_run_max <= 12'h000;
            r_run_min <= 12'hFFF;
            r_max     <= '0;
            r_min     <= '0;
            r_amp     <= '0;
            r_valid   <= 1'b0;
            r_win_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            if (!en_i) begin
                r_cnt     <= '0;
                r_run_max <= 12'h000;
                r_run_min <= 12'hFFF;
            end else if (w_acc) begin
                if (w_last) begin
                    r_max     <= w_max;
                    r_min     <= w_min;
                    r_amp     <= w_max - w_min;
                    r_valid   <= 1'b1;
                    r_win_cnt <= r_win_cnt + 16'd1;
                    r_cnt     <= '0;
                    r_run_max <= 12'h000;
                    r_run_min <= 12'hFFF;
                end else begin
                    r_run_max <= w_max;
                    r_run_min <= w_min;
                    r_cnt     <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign max_o     = r_max;
    assign min_o     = r_min;
    assign amp_o     = r_amp;
    assign valid_o   = r_valid;
    assign win_cnt_o = r_win_cnt;

endmodule

// File: tb/tb_adc_window_peak.sv
// Scoreboard bench for adc_window_peak: LOG2_WIN=2 main instance,
// LOG2_WIN=1 instance for the window-counter wrap check.
module tb_adc_window_peak;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] din;
    logic        vin;
    logic [11:0] mx, mn, amp;
    logic        vout;
    logic [15:0] wc;

    logic        rst1;
    logic        en1;
    logic [11:0] din1;
    logic        vin1;
    logic [11:0] mx1, mn1, amp1;
    logic        vout1;
    logic [15:0] wc1;

`ifdef ADC_WIN_MEAN_EN
    logic [11:0] mean;
    logic [11:0] mean1;
`endif

    always #5 clk = ~clk;

    adc_window_peak #(.LOG2_WIN(2)) dut (
        .clk(clk), .rst(rst), .en_i(en), .data_i(din), .valid_i(vin),
        .max_o(mx), .min_o(mn), .amp_o(amp),
`ifdef ADC_WIN_MEAN_EN
        .mean_o(mean),
`endif
        .valid_o(vout), .win_cnt_o(wc)
    );

    adc_window_peak #(.LOG2_WIN(1)) dut1 (
        .clk(clk), .rst(rst1), .en_i(en1), .data_i(din1), .valid_i(vin1),
        .max_o(mx1), .min_o(mn1), .amp_o(amp1),
`ifdef ADC_WIN_MEAN_EN
        .mean_o(mean1),
`endif
        .valid_o(vout1), .win_cnt_o(wc1)
    );

    typedef struct {
        logic [11:0] mx;
        logic [11:0] mn;
        logic [11:0] amp;
        logic [11:0] mean;
        logic [15:0] wc;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model of the LOG2_WIN=2 instance
    int          m_cnt;
    logic [11:0] m_max, m_min;
    int          m_sum;
    logic [15:0] m_win;

    task automatic model_clear();
        m_cnt = 0;
        m_max = 12'h000;
        m_min = 12'hFFF;
        m_sum = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        vin = 1'b0;
        din = '0;
        q.delete();
        model_clear();
        m_win = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic e, input logic v, input logic [11:0] d);
        exp_t x;
        en  = e;
        vin = v;
        din = d;
        @(posedge clk);
        if (!e) begin
            model_clear();
        end else if (v) begin
            if (d > m_max) m_max = d;
            if (d < m_min) m_min = d;
            m_sum = m_sum + int'(d);
            if (m_cnt == 3) begin
                m_win  = m_win + 16'd1;
                x.mx   = m_max;
                x.mn   = m_min;
                x.amp  = m_max - m_min;
                x.mean = 12'(m_sum / 4);
                x.wc   = m_win;
                q.push_back(x);
                model_clear();
            end else begin
                m_cnt++;
            end
        end
        #1;
        vin = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (vout) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_valid: valid_o=1 expected=0");
                end else begin
                    e = q.pop_front();
                    n_chk++;
                    if ({mx, mn, amp, wc} !== {e.mx, e.mn, e.amp, e.wc}) begin
                        n_fail++;
                        $display("FAIL sb_result: max=%h min=%h amp=%h cnt=%h expected max=%h min=%h amp=%h cnt=%h",
                                 mx, mn, amp, wc, e.mx, e.mn, e.amp, e.wc);
                    end
`ifdef ADC_WIN_MEAN_EN
                    n_chk++;
                    if (mean !== e.mean) begin
                        n_fail++;
                        $display("FAIL sb_mean: mean=%h expected=%h", mean, e.mean);
                    end
`endif
                end
            end else if (q.size() != 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_missing_valid: valid_o=0 expected=1");
                void'(q.pop_front());
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_chk++;
        if ({mx, mn, amp, vout, wc} !== 53'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: max=%h min=%h amp=%h v=%b cnt=%h expected all zero",
                     mx, mn, amp, vout, wc);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        cyc(1, 1, 12'h100);
        cyc(1, 1, 12'h300);
        cyc(1, 1, 12'h050);
        cyc(1, 1, 12'h200);
        repeat (4) cyc(1, 0, 12'hFFF);
        n_chk++;
        if ({mx, mn, amp, vout, wc} !== {12'h300, 12'h050, 12'h2B0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL basic_hold: max=%h min=%h amp=%h v=%b cnt=%h expected 300 050 2b0 0 1",
                     mx, mn, amp, vout, wc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (8) cyc(1, 1, 12'hABC);
        cyc(1, 0, 12'h000);
        cyc(1, 0, 12'h000);
        n_chk++;
        if ({wc, amp} !== {16'd2, 12'h000}) begin
            n_fail++;
            $display("FAIL b2b_count: cnt=%h amp=%h expected cnt=2 amp=0", wc, amp);
        end
    endtask

    task automatic test_en_low();
        do_reset();
        cyc(1, 1, 12'hF00);
        cyc(1, 1, 12'h001);
        cyc(1, 1, 12'h800);
        cyc(0, 1, 12'h900);
        cyc(1, 1, 12'h010);
        cyc(1, 1, 12'h020);
        cyc(1, 1, 12'h030);
        cyc(1, 1, 12'h040);
        cyc(1, 0, 12'h000);
        n_chk++;
        if ({mx, mn, amp, wc} !== {12'h040, 12'h010, 12'h030, 16'd1}) begin
            n_fail++;
            $display("FAIL en_low_window: max=%h min=%h amp=%h cnt=%h expected 040 010 030 1",
                     mx, mn, amp, wc);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        for (int i = 0; i < 4 * 7; i++) begin
            if (i % 7 == 6) cyc(1, 1, 12'(200 + 37 * i));
            else            cyc(1, 0, 12'($urandom_range(0, 4095)));
        end
        repeat (3) cyc(1, 0, 12'hFFF);
        n_chk++;
        if (wc !== 16'd1) begin
            n_fail++;
            $display("FAIL sparse_count: cnt=%h expected=1", wc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (4) cyc(1, 1, 12'h555);
        cyc(1, 1, 12'h123);
        cyc(1, 1, 12'h456);
        rst = 1'b1;
        #1;
        n_chk++;
        if ({mx, mn, amp, vout, wc} !== 53'd0) begin
            n_fail++;
            $display("FAIL reset_mid: max=%h min=%h amp=%h v=%b cnt=%h expected all zero",
                     mx, mn, amp, vout, wc);
        end
        do_reset();
        cyc(1, 1, 12'hFFF);
        cyc(1, 1, 12'h000);
        cyc(1, 1, 12'h800);
        cyc(1, 1, 12'h800);
        cyc(1, 0, 12'h000);
    endtask

    task automatic test_wrap();
        rst1 = 1'b1;
        en1  = 1'b1;
        vin1 = 1'b0;
        din1 = '0;
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        force dut1.r_win_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut1.r_win_cnt;
        n_chk++;
        if (wc1 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preset: cnt=%h expected=ffff", wc1);
        end
        vin1 = 1'b1;
        din1 = 12'h123;
        @(posedge clk);
        #1;
        din1 = 12'h456;
        @(posedge clk);
        #1;
        vin1 = 1'b0;
        n_chk++;
        if ({vout1, wc1, mx1, mn1, amp1} !== {1'b1, 16'h0000, 12'h456, 12'h123, 12'h333}) begin
            n_fail++;
            $display("FAIL wrap_result: v=%b cnt=%h max=%h min=%h amp=%h expected 1 0000 456 123 333",
                     vout1, wc1, mx1, mn1, amp1);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (vout1 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pulse_width: valid_o=%b expected=0", vout1);
        end
    endtask

    initial begin
        rst1 = 1'b1;
        en1  = 1'b0;
        vin1 = 1'b0;
        din1 = '0;
        en   = 1'b0;
        vin  = 1'b0;
        din  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_en_low();
        test_sparse();
        test_reset_mid();
        test_wrap();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: pending=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
